// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file.
package wb_regfile_pkg;

    localparam int          XLEN_DEFAULT    = 32;
    localparam int          NUM_REGS        = 32;
    localparam logic [4:0]  REG_ZERO        = 5'd0;
    localparam logic [4:0]  REG_SP          = 5'd2;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_7FFC;

endpackage : wb_regfile_pkg

// File: rtl/reg_bypass_mux.sv
// One register-file read port: x0 forced to zero, write-through bypass,
// otherwise a select from the stored array.
module reg_bypass_mux
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            rst,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] regs [1:NUM_REGS-1],
    output logic [XLEN-1:0] rs_data
);

    logic            bypass_hit;
    logic [XLEN-1:0] stored_data;

    // Bypass only for a write that will really commit this cycle (never during reset).
    assign bypass_hit = wb_reg_write && !rst && (wb_rd != REG_ZERO) && (rs_addr == wb_rd);

    // Array select; index 0 has no storage and falls through to zero.
    always_comb begin
        stored_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs_addr == 5'(i)) begin
                stored_data = regs[i];
            end
        end
    end

    // Final port value: zero register first, then bypass, then stored value.
    always_comb begin
        rs_data = stored_data;
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end else if (bypass_hit) begin
            rs_data = wb_data;
        end
    end

endmodule : reg_bypass_mux

// File: rtl/wb_regfile.sv
// 31-entry integer register file (x0 hard-wired to zero) with two bypassed
// read ports, an un-bypassed debug port and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int            XLEN    = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WbRegWrite,
    input  logic [4:0]      WbRd,
    input  logic [XLEN-1:0] WbData,
    input  logic [4:0]      Rs1Addr,
    input  logic [4:0]      Rs2Addr,
    output logic [XLEN-1:0] Rs1Data,
    output logic [XLEN-1:0] Rs2Data,
    input  logic [4:0]      DbgAddr,
    output logic [XLEN-1:0] DbgData,
    output logic [31:0]     WbCount
);

    logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
    logic [XLEN-1:0] regs_d [1:NUM_REGS-1];
    logic [31:0]     wb_count_q;
    logic [31:0]     wb_count_d;
    logic            wr_commit;

    // A write to x0 is dropped entirely, including the count.
    assign wr_commit = WbRegWrite && (WbRd != REG_ZERO);

    // Next-state for the array and counter; a held write re-commits every cycle.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wr_commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (WbRd == 5'(i)) begin
                    regs_d[i] = WbData;
                end
            end
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    // State update; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Debug read sees only stored contents, never the in-flight write.
    always_comb begin
        DbgData = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (DbgAddr == 5'(i)) begin
                DbgData = regs_q[i];
            end
        end
    end

    assign WbCount = wb_count_q;

    reg_bypass_mux #(.XLEN(XLEN)) u_rs1_port (
        .rst          (rst),
        .wb_reg_write (WbRegWrite),
        .wb_rd        (WbRd),
        .wb_data      (WbData),
        .rs_addr      (Rs1Addr),
        .regs         (regs_q),
        .rs_data      (Rs1Data)
    );

    reg_bypass_mux #(.XLEN(XLEN)) u_rs2_port (
        .rst          (rst),
        .wb_reg_write (WbRegWrite),
        .wb_rd        (WbRd),
        .wb_data      (WbData),
        .rs_addr      (Rs2Addr),
        .regs         (regs_q),
        .rs_data      (Rs2Data)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios followed by random
// traffic, all compared against a plain array model of the register file.
module tb_wb_regfile;

    localparam int          XLEN    = 32;
    localparam logic [31:0] SP_INIT = 32'h0000_7FFC;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic            WbRegWrite;
    logic [4:0]      WbRd;
    logic [XLEN-1:0] WbData;
    logic [4:0]      Rs1Addr;
    logic [4:0]      Rs2Addr;
    logic [XLEN-1:0] Rs1Data;
    logic [XLEN-1:0] Rs2Data;
    logic [4:0]      DbgAddr;
    logic [XLEN-1:0] DbgData;
    logic [31:0]     WbCount;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(XLEN), .SP_INIT(SP_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .WbRegWrite (WbRegWrite),
        .WbRd       (WbRd),
        .WbData     (WbData),
        .Rs1Addr    (Rs1Addr),
        .Rs2Addr    (Rs2Addr),
        .Rs1Data    (Rs1Data),
        .Rs2Data    (Rs2Data),
        .DbgAddr    (DbgAddr),
        .DbgData    (DbgData),
        .WbCount    (WbCount)
    );

    // ---------------- reference model ----------------
    logic [XLEN-1:0] model_x [32];
    logic [31:0]     model_count;
    int              checks = 0;
    int              errors = 0;

    // Value a read port should show right now: x0 is zero, a committing write
    // to the same index is forwarded, otherwise the stored value.
    function automatic logic [XLEN-1:0] exp_port(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (WbRegWrite && !rst && WbRd != 5'd0 && a == WbRd) return WbData;
        return model_x[a];
    endfunction

    function automatic logic [XLEN-1:0] exp_dbg(input logic [4:0] a);
        if (a == 5'd0) return '0;
        return model_x[a];
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " rs1"}, Rs1Data, exp_port(Rs1Addr));
        check({tag, " rs2"}, Rs2Data, exp_port(Rs2Addr));
        check({tag, " dbg"}, DbgData, exp_dbg(DbgAddr));
        check({tag, " cnt"}, WbCount, model_count);
    endtask

    // ---------------- driver tasks ----------------
    // Apply the model's view of the clock edge, then advance past it.
    task automatic tick();
        if (rst) begin
            foreach (model_x[i]) model_x[i] = '0;
            model_x[2]  = SP_INIT;
            model_count = '0;
        end else if (WbRegWrite && WbRd != 5'd0) begin
            model_x[WbRd] = WbData;
            model_count   = model_count + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] rd, input logic [XLEN-1:0] d);
        WbRegWrite = en;
        WbRd       = rd;
        WbData     = d;
    endtask

    task automatic drive_rd(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        Rs1Addr = a1;
        Rs2Addr = a2;
        DbgAddr = ad;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] cnt_before;
        foreach (model_x[i]) model_x[i] = 'x;
        model_count = 'x;
        rst = 1'b1;
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd0, 5'd0, 5'd0);

        // Reset
        tick();
        rst = 1'b0;
        drive_rd(5'd2, 5'd5, 5'd2);
        check("reset x2", Rs1Data, 32'h0000_7FFC);
        check("reset x5", Rs2Data, 32'h0);
        check("reset cnt", WbCount, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive_rd(5'(i), 5'(31 - i), 5'(i));
            check_all("reset sweep");
        end

        // Write then read
        drive_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd5, 5'd0, 5'd5);
        check("wr x5", Rs1Data, 32'hDEAD_BEEF);
        check("wr cnt", WbCount, 32'd1);

        // Same-cycle bypass on both ports, debug sees old value
        drive_wr(1'b1, 5'd7, 32'h1234_5678);
        drive_rd(5'd7, 5'd7, 5'd7);
        check("byp rs1", Rs1Data, 32'h1234_5678);
        check("byp rs2", Rs2Data, 32'h1234_5678);
        check("byp dbg", DbgData, 32'h0);
        tick();
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd7, 5'd5, 5'd7);
        check_all("after byp");

        // x0 write is dropped
        drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive_rd(5'd0, 5'd0, 5'd0);
        check("x0 same", Rs1Data, 32'h0);
        tick();
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd0, 5'd0, 5'd0);
        check("x0 after", Rs1Data, 32'h0);
        check("x0 cnt", WbCount, 32'd2);

        // Reset collides with write; no bypass while in reset
        rst = 1'b1;
        drive_wr(1'b1, 5'd2, 32'h0000_0010);
        drive_rd(5'd2, 5'd5, 5'd2);
        check("rstcol rs1 nobyp", Rs1Data, 32'h0000_7FFC);
        check("rstcol rs2 stored", Rs2Data, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd2, 5'd5, 5'd7);
        check("rstcol x2", Rs1Data, 32'h0000_7FFC);
        check("rstcol x5", Rs2Data, 32'h0);
        check("rstcol x7", DbgData, 32'h0);
        check("rstcol cnt", WbCount, 32'd0);

        // Back-to-back writes to the same register
        drive_wr(1'b1, 5'd9, 32'd1);
        tick();
        drive_wr(1'b1, 5'd9, 32'd2);
        tick();
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd9, 5'd9, 5'd9);
        check("b2b x9", Rs1Data, 32'd2);
        check("b2b dbg", DbgData, 32'd2);
        check("b2b cnt", WbCount, 32'd2);

        // Held write re-commits every cycle
        cnt_before = model_count;
        drive_wr(1'b1, 5'd31, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) tick();
        drive_wr(1'b0, 5'd0, '0);
        drive_rd(5'd31, 5'd1, 5'd31);
        check("hold x31", DbgData, 32'hA5A5_0001);
        check("hold cnt", WbCount, cnt_before + 32'd3);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive_wr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                drive_rd(WbRd, 5'($urandom_range(0, 31)), WbRd);
            end else begin
                drive_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            check_all("rand");
            tick();
        end
        rst = 1'b0;
        drive_wr(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i++) begin
            drive_rd(5'(i), 5'(i), 5'(i));
            check_all("final sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter SP_INIT, default 32'h0000_7FFC, reset value of register x2 (stack pointer).
REQ-002 Parameter XLEN, default 32, data width of every register and data port.
REQ-003 clk  input  1  single clock; all state updates on the posedge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 WbRegWrite  input  1  write-back enable from the MEM/WB register.
REQ-006 WbRd  input  5  write-back destination register index.
REQ-007 WbData  input  XLEN  write-back data.
REQ-008 Rs1Addr  input  5  read port 1 index (decode stage).
REQ-009 Rs2Addr  input  5  read port 2 index (decode stage).
REQ-010 Rs1Data  output  XLEN  read port 1 data.
REQ-011 Rs2Data  output  XLEN  read port 2 data.
REQ-012 DbgAddr  input  5  debug/display read index.
REQ-013 DbgData  output  XLEN  debug read data; no bypass.
REQ-014 WbCount  output  32  count of committed register writes.

Function
REQ-015 Storage SHALL be 31 XLEN-bit registers x1..x31; x0 SHALL have no storage and SHALL always read 0.
REQ-016 A write SHALL commit at the posedge when WbRegWrite=1, WbRd!=0 and rst=0; x[WbRd] becomes WbData.
REQ-017 Writes with WbRd=0 SHALL be discarded, leaving all state and WbCount unchanged.
REQ-018 Rs1Data and Rs2Data SHALL be combinational; latency is 0 cycles from address change.
REQ-019 Write-through bypass: when WbRegWrite=1, WbRd!=0, rst=0 and RsNAddr==WbRd, RsNData SHALL equal WbData in the same cycle.
REQ-020 Bypass SHALL apply independently to each read port; both ports matching WbRd SHALL both return WbData.
REQ-021 The bypass SHALL be suppressed while rst=1; reads then return the stored (pre-reset) array contents until the reset edge.
REQ-022 DbgData SHALL return the stored value of x[DbgAddr] only (0 for x0), with no bypass.
REQ-023 WbCount SHALL increment by 1 at each committed write (REQ-016) and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-024 Consecutive writes to the same register on back-to-back cycles SHALL each commit; the last one wins.
REQ-025 There SHALL be no stall input; the MEM/WB register's hold behaviour keeps WbRegWrite/WbRd/WbData stable, and a held write SHALL re-commit each cycle it is presented, incrementing WbCount each time.

Reset
REQ-026 At the posedge with rst=1: x1 and x3..x31 SHALL become 0, x2 SHALL become SP_INIT, WbCount SHALL become 0.
REQ-027 A write presented in the same cycle as rst=1 SHALL be discarded; reset takes priority.
REQ-028 After the reset edge, Rs1Data/Rs2Data/DbgData SHALL read 0 for all indices except 2, which reads SP_INIT.
REQ-029 Reset asserted mid-program SHALL clear state at the next edge regardless of pending writes.

Structure
REQ-030 Shared package SHALL hold XLEN default, NUM_REGS=32, REG_ZERO=5'd0, REG_SP=5'd2 and the default SP_INIT.
REQ-031 One sub-module, reg_bypass_mux, SHALL implement one read port (zero check, bypass compare, array select) and be instantiated twice.
REQ-032 The storage array, write logic and WbCount SHALL live in wb_regfile itself.

Verification
REQ-033 Reset: rst=1 one cycle -> Rs1Addr=2 reads 32'h0000_7FFC; Rs2Addr=5 reads 0; WbCount=0.
REQ-034 Write/read: WbRegWrite=1, WbRd=5, WbData=32'hDEAD_BEEF -> after the edge Rs1Addr=5 reads 32'hDEAD_BEEF; WbCount=1.
REQ-035 Bypass: same cycle as write WbRd=7, WbData=32'h1234_5678 with Rs1Addr=Rs2Addr=7 -> both ports read 32'h1234_5678 before the edge; DbgAddr=7 reads the old value 0.
REQ-036 x0: write WbRd=0, WbData=32'hFFFF_FFFF -> Rs1Addr=0 reads 0 in the same cycle and after the edge; WbCount unchanged.
REQ-037 Reset collision: rst=1 with write WbRd=2, WbData=32'h0000_0010 -> x2 reads SP_INIT after the edge; WbCount=0; no bypass during rst.
REQ-038 Back-to-back: writes x9=1 then x9=2 on consecutive cycles -> x9 reads 2; WbCount increments by 2.
